// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite register bank: N_REGS 32-bit registers with byte strobes, SLVERR on
// out-of-range accesses, register contents and per-register write pulses exported.
module axi_lite_reg_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int N_REGS     = 8
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic [ADDR_WIDTH-1:0]        awaddr,
  input  logic                         awvalid,
  output logic                         awready,
  input  logic [DATA_WIDTH-1:0]        wdata,
  input  logic [DATA_WIDTH/8-1:0]      wstrb,
  input  logic                         wvalid,
  output logic                         wready,
  output logic [1:0]                   bresp,
  output logic                         bvalid,
  input  logic                         bready,
  input  logic [ADDR_WIDTH-1:0]        araddr,
  input  logic                         arvalid,
  output logic                         arready,
  output logic [DATA_WIDTH-1:0]        rdata,
  output logic [1:0]                   rresp,
  output logic                         rvalid,
  input  logic                         rready,
  output logic [DATA_WIDTH*N_REGS-1:0] reg_o,
  output logic [N_REGS-1:0]            wr_pulse_o
);

  localparam int IDX_W = (N_REGS > 1) ? $clog2(N_REGS) : 1;
  localparam int NB    = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] RANGE_END = ADDR_WIDTH'(4 * N_REGS);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic                  r_aw_held, r_w_held, r_bvalid, r_rvalid;
  logic [1:0]            r_bresp, r_rresp;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic [DATA_WIDTH-1:0] r_wdata, r_rdata;
  logic [NB-1:0]         r_wstrb;
  logic [N_REGS-1:0]     r_wr_pulse;
  logic [DATA_WIDTH-1:0] r_regs [N_REGS];

  logic                  w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs, w_commit;
  logic [ADDR_WIDTH-1:0] w_waddr;
  logic [DATA_WIDTH-1:0] w_wdata, w_rd_word;
  logic [NB-1:0]         w_wstrb;
  logic                  w_wr_in_range, w_rd_in_range;
  logic [IDX_W-1:0]      w_widx, w_ridx;

  // Readies derive only from held/valid state, never from the same channel's valid.
  assign awready = ~r_aw_held;
  assign wready  = ~r_w_held;
  assign arready = ~r_rvalid;
  assign bvalid  = r_bvalid;
  assign bresp   = r_bresp;
  assign rvalid  = r_rvalid;
  assign rresp   = r_rresp;
  assign rdata   = r_rdata;
  assign wr_pulse_o = r_wr_pulse;

  assign w_aw_hs  = awvalid & ~r_aw_held;
  assign w_w_hs   = wvalid & ~r_w_held;
  assign w_b_hs   = r_bvalid & bready;
  assign w_ar_hs  = arvalid & ~r_rvalid;
  assign w_r_hs   = r_rvalid & rready;
  assign w_commit = (r_aw_held | w_aw_hs) & (r_w_held | w_w_hs) & ~r_bvalid;

  assign w_waddr = r_aw_held ? r_awaddr : awaddr;
  assign w_wdata = r_w_held  ? r_wdata  : wdata;
  assign w_wstrb = r_w_held  ? r_wstrb  : wstrb;
  assign w_wr_in_range = (w_waddr < RANGE_END);
  assign w_rd_in_range = (araddr < RANGE_END);
  assign w_widx = w_waddr[2 +: IDX_W];
  assign w_ridx = araddr[2 +: IDX_W];

  genvar g;
  generate
    for (g = 0; g < N_REGS; g++) begin : g_reg_out
      assign reg_o[g*DATA_WIDTH +: DATA_WIDTH] = r_regs[g];
    end
  endgenerate

  always_comb begin
    w_rd_word = '0;
    for (int k = 0; k < N_REGS; k++) begin
      if (w_ridx == IDX_W'(k)) begin
        w_rd_word = r_regs[k];
      end else begin
        w_rd_word = w_rd_word;
      end
    end
  end

  // Write channel: capture AW/W independently, commit once both are present.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_aw_held  <= 1'b0;
      r_w_held   <= 1'b0;
      r_awaddr   <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_bvalid   <= 1'b0;
      r_bresp    <= RESP_OKAY;
      r_wr_pulse <= '0;
      for (int k = 0; k < N_REGS; k++) r_regs[k] <= '0;
    end else begin
      r_wr_pulse <= '0;
      if (w_b_hs) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        r_bvalid  <= 1'b0;
      end else begin
        if (w_aw_hs) begin
          r_aw_held <= 1'b1;
          r_awaddr  <= awaddr;
        end
        if (w_w_hs) begin
          r_w_held <= 1'b1;
          r_wdata  <= wdata;
          r_wstrb  <= wstrb;
        end
        if (w_commit) begin
          r_bvalid <= 1'b1;
          r_bresp  <= w_wr_in_range ? RESP_OKAY : RESP_SLVERR;
          for (int k = 0; k < N_REGS; k++) begin
            if (w_wr_in_range && (w_widx == IDX_W'(k))) begin
              r_wr_pulse[k] <= 1'b1;
              for (int b = 0; b < NB; b++) begin
                if (w_wstrb[b]) r_regs[k][b*8 +: 8] <= w_wdata[b*8 +: 8];
              end
            end
          end
        end
      end
    end
  end

  // Read channel: data is sampled at the AR edge, so a same-edge write is not seen.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_rvalid <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
    end else if (w_ar_hs) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_rd_in_range ? w_rd_word : '0;
      r_rresp  <= w_rd_in_range ? RESP_OKAY : RESP_SLVERR;
    end else if (w_r_hs) begin
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= r_rvalid;
    end
  end

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Directed self-checking bench for axi_lite_reg_slave (N_REGS = 8).
module tb_axi_lite_reg_slave;

  logic        aclk = 1'b0;
  logic        areset;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;
  logic [255:0] reg_o;
  logic [7:0]  wr_pulse_o;

  int n_checks = 0;
  int n_fails  = 0;
  logic [1:0]  t_resp;
  logic [7:0]  t_pulse;
  logic [31:0] t_data;

  always #5 aclk = ~aclk;

  axi_lite_reg_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .N_REGS(8)) dut (
    .aclk(aclk), .areset(areset),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .reg_o(reg_o), .wr_pulse_o(wr_pulse_o)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp, output logic [7:0] pulse);
    int n;
    n = 0;
    while (!(awready && wready) && n < 20) begin step(); n++; end
    awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1; bready = 1'b1;
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 20) begin step(); n++; end
    check_eq("wr_bvalid", bvalid, 1);
    resp = bresp; pulse = wr_pulse_o;
    step();
    bready = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    n = 0;
    while (!arready && n < 20) begin step(); n++; end
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    step();
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin step(); n++; end
    check_eq("rd_rvalid", rvalid, 1);
    d = rdata; resp = rresp;
    step();
    rready = 1'b0;
  endtask

  initial begin
    areset = 1'b1;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arvalid = 1'b0; rready = 1'b0;
    repeat (2) step();
    check_eq("rst_awready", awready, 1);
    check_eq("rst_wready", wready, 1);
    check_eq("rst_arready", arready, 1);
    check_eq("rst_bvalid", bvalid, 0);
    check_eq("rst_rvalid", rvalid, 0);
    check_eq("rst_rdata", rdata, 0);
    check_eq("rst_pulse", wr_pulse_o, 0);
    for (int k = 0; k < 8; k++) check_eq("rst_reg", reg_o[k*32 +: 32], 0);
    areset = 1'b0;
    step();

    // 1: AW and W together
    awaddr = 32'h4; awvalid = 1'b1; wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b1;
    check_eq("t1_awready_pre", awready, 1);
    check_eq("t1_bvalid_pre", bvalid, 0);
    step();
    awvalid = 1'b0; wvalid = 1'b0;
    check_eq("t1_bvalid", bvalid, 1);
    check_eq("t1_bresp", bresp, 0);
    check_eq("t1_pulse", wr_pulse_o, 8'h02);
    check_eq("t1_reg1", reg_o[63:32], 32'hDEADBEEF);
    check_eq("t1_awready_busy", awready, 0);
    step();
    bready = 1'b0;
    check_eq("t1_bvalid_done", bvalid, 0);
    check_eq("t1_pulse_done", wr_pulse_o, 0);
    check_eq("t1_awready_back", awready, 1);
    check_eq("t1_wready_back", wready, 1);

    // 2: W three cycles ahead of AW
    do_write(32'h8, 32'h11223344, 4'hF, t_resp, t_pulse);
    check_eq("t2_pre_resp", t_resp, 0);
    check_eq("t2_pre_reg2", reg_o[95:64], 32'h11223344);
    wdata = 32'h000000AA; wstrb = 4'h1; wvalid = 1'b1;
    step();
    wvalid = 1'b0; wdata = 32'hFFFFFFFF; wstrb = 4'hF;
    for (int i = 0; i < 3; i++) begin
      check_eq("t2_wready_low", wready, 0);
      check_eq("t2_no_bvalid", bvalid, 0);
      check_eq("t2_awready", awready, 1);
      if (i < 2) step();
    end
    awaddr = 32'h8; awvalid = 1'b1;
    step();
    awvalid = 1'b0;
    check_eq("t2_bvalid", bvalid, 1);
    check_eq("t2_bresp", bresp, 0);
    check_eq("t2_reg2", reg_o[95:64], 32'h112233AA);
    check_eq("t2_pulse", wr_pulse_o, 8'h04);
    step();
    check_eq("t2_bvalid_hold", bvalid, 1);
    check_eq("t2_pulse_one", wr_pulse_o, 0);
    check_eq("t2_wready_hold", wready, 0);
    bready = 1'b1;
    step();
    bready = 1'b0;
    check_eq("t2_bvalid_done", bvalid, 0);
    check_eq("t2_wready_back", wready, 1);
    step();
    check_eq("t2_single_b", bvalid, 0);

    // 3: read with rready held low
    araddr = 32'h4; arvalid = 1'b1; rready = 1'b0;
    step();
    arvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_eq("t3_rvalid", rvalid, 1);
      check_eq("t3_rdata", rdata, 32'hDEADBEEF);
      check_eq("t3_rresp", rresp, 0);
      check_eq("t3_arready", arready, 0);
      if (i < 4) step();
    end
    rready = 1'b1;
    step();
    rready = 1'b0;
    check_eq("t3_rvalid_done", rvalid, 0);
    check_eq("t3_arready_back", arready, 1);
    do_read(32'h6, t_data, t_resp);
    check_eq("t3_unaligned_data", t_data, 32'hDEADBEEF);

    // 4: out of range
    do_write(32'h40, 32'h12345678, 4'hF, t_resp, t_pulse);
    check_eq("t4_bresp", t_resp, 2'b10);
    check_eq("t4_pulse", t_pulse, 0);
    check_eq("t4_reg0", reg_o[31:0], 0);
    check_eq("t4_reg1", reg_o[63:32], 32'hDEADBEEF);
    check_eq("t4_reg2", reg_o[95:64], 32'h112233AA);
    for (int k = 3; k < 8; k++) check_eq("t4_regk", reg_o[k*32 +: 32], 0);
    do_read(32'h40, t_data, t_resp);
    check_eq("t4_rresp", t_resp, 2'b10);
    check_eq("t4_rdata", t_data, 0);
    do_write(32'h1C, 32'h00C0FFEE, 4'h0, t_resp, t_pulse);
    check_eq("t4_strb0_resp", t_resp, 0);
    check_eq("t4_strb0_pulse", t_pulse, 8'h80);
    check_eq("t4_strb0_reg7", reg_o[255:224], 0);

    // 5: same-edge write and read of reg3
    do_write(32'hC, 32'h1, 4'hF, t_resp, t_pulse);
    awaddr = 32'hC; awvalid = 1'b1; wdata = 32'h5A5A5A5A; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b1;
    araddr = 32'hC; arvalid = 1'b1; rready = 1'b0;
    step();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    check_eq("t5_rvalid", rvalid, 1);
    check_eq("t5_rdata_old", rdata, 32'h1);
    check_eq("t5_bvalid", bvalid, 1);
    check_eq("t5_reg3", reg_o[127:96], 32'h5A5A5A5A);
    rready = 1'b1;
    step();
    rready = 1'b0; bready = 1'b0;
    do_read(32'hC, t_data, t_resp);
    check_eq("t5_rdata_new", t_data, 32'h5A5A5A5A);

    // 6: reset with both responses pending
    awaddr = 32'h0; awvalid = 1'b1; wdata = 32'hCAFEF00D; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b0;
    araddr = 32'h4; arvalid = 1'b1; rready = 1'b0;
    step();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    check_eq("t6_bvalid_pre", bvalid, 1);
    check_eq("t6_rvalid_pre", rvalid, 1);
    #2 areset = 1'b1;
    #1;
    check_eq("t6_bvalid_rst", bvalid, 0);
    check_eq("t6_rvalid_rst", rvalid, 0);
    check_eq("t6_pulse_rst", wr_pulse_o, 0);
    check_eq("t6_awready_rst", awready, 1);
    check_eq("t6_wready_rst", wready, 1);
    check_eq("t6_arready_rst", arready, 1);
    for (int k = 0; k < 8; k++) check_eq("t6_reg_rst", reg_o[k*32 +: 32], 0);
    step();
    areset = 1'b0;
    step();
    check_eq("t6_awready_after", awready, 1);
    check_eq("t6_bvalid_after", bvalid, 0);
    do_read(32'h4, t_data, t_resp);
    check_eq("t6_reg1_read", t_data, 0);
    check_eq("t6_reg1_resp", t_resp, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
